mult20_arbiter: RTL and testbench

//  Shares one signed 20x20 multiplier among NREQ requesters.

---
 rtl/mult20_arbiter.sv | 117 +++++++++++
 tb/tb_mult20_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mult20_arbiter.sv
// Shared signed 20x20 multiplier with a round-robin front end.
// One operand pair is granted per cycle and its product returns PIPE cycles later, tagged with its requester.
module mult20_arbiter #(
  parameter  int NREQ = 4,
  parameter  int PIPE = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*20-1:0]     req_a,
  input  logic [NREQ*20-1:0]     req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic signed [39:0]     res_m,
  output logic [IDW-1:0]         res_id,
  output logic                   busy
);

  logic                 en;
  logic                 found;
  logic                 xfer;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       grant;
  logic signed [19:0]   grant_a;
  logic signed [19:0]   grant_b;
  logic [PIPE-1:0]      vld;
  logic [IDW-1:0]       id_q [PIPE];

  // A held result freezes the whole pipe, empty stages included.
  assign res_valid = vld[PIPE-1];
  assign en        = !(res_valid && !res_ready);
  assign busy      = |vld;
  assign res_id    = id_q[PIPE-1];

  // NOTE: combinational blocks use blocking '=' with every output given a default first, so no latch is inferred.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && en && found) req_ready[grant] = 1'b1;
  end

  assign xfer    = |(req_valid & req_ready);
  assign grant_a = req_a[int'(grant)*20 +: 20];
  assign grant_b = req_b[int'(grant)*20 +: 20];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      vld <= '0;
      for (int s = 0; s < PIPE; s++) id_q[s] <= '0;
    end else if (en) begin
      if (xfer) ptr <= (grant == IDW'(NREQ-1)) ? '0 : grant + IDW'(1);
      vld[0] <= xfer;
      if (xfer) id_q[0] <= grant;
      for (int s = 1; s < PIPE; s++) begin
        vld[s] <= vld[s-1];
        if (vld[s-1]) id_q[s] <= id_q[s-1];
      end
    end
  end

  // Data registers load only behind a valid entry, so the output holds its last product through bubbles.
  if (PIPE == 1) begin : g_pipe1
    logic signed [39:0] m_q;

    // NOTE: the datapath registers are reset too, because the result bus must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_q <= '0;
      end else if (en && xfer) begin
        m_q <= 40'(grant_a) * 40'(grant_b);
      end
    end

    assign res_m = m_q;
  end else begin : g_pipen
    logic signed [19:0] a_q;
    logic signed [19:0] b_q;
    logic signed [39:0] m_q [1:PIPE-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        for (int s = 1; s < PIPE; s++) m_q[s] <= '0;
      end else if (en) begin
        if (xfer) begin
          a_q <= grant_a;
          b_q <= grant_b;
        end
        if (vld[0]) m_q[1] <= 40'(a_q) * 40'(b_q);
        for (int s = 2; s < PIPE; s++) begin
          if (vld[s-1]) m_q[s] <= m_q[s-1];
        end
      end
    end

    assign res_m = m_q[PIPE-1];
  end

endmodule

// File: tb/tb_mult20_arbiter.sv
// Bench for mult20_arbiter (NREQ=4, PIPE=2): vector table plus hand-written latency, reset and stall sequences,
// with results checked against a scoreboard filled at grant time.
module tb_mult20_arbiter;
  localparam int NREQ = 4;
  localparam int PIPE = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*20-1:0] req_a;
  logic [NREQ*20-1:0] req_b;
  logic               res_valid;
  logic               res_ready;
  logic signed [39:0] res_m;
  logic [1:0]         res_id;
  logic               busy;

  mult20_arbiter #(.NREQ(NREQ), .PIPE(PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_m(res_m), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] id; logic signed [39:0] m; } exp_t;
  typedef struct { logic [3:0] valid; logic rr; logic [3:0] exp_ready; } vec_t;

  exp_t               sb[$];
  vec_t               vecs[$];
  logic signed [19:0] a_op [NREQ];
  logic signed [19:0] b_op [NREQ];
  int                 tests_run = 0;
  int                 tests_failed = 0;
  logic               stalled = 1'b0;
  logic signed [39:0] hold_m;
  logic [1:0]         hold_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      a_op[i] = 20'($urandom);
      b_op[i] = 20'($urandom);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[20*i +: 20] = a_op[i];
      req_b[20*i +: 20] = b_op[i];
    end
  endtask

  // One clock: check a frozen output, drive, check the grant, score any result consumed on the coming edge.
  task automatic cycle(input logic [3:0] v, input logic rr, input logic [3:0] exp_ready);
    exp_t e;
    if (stalled) begin
      check("stall_valid", res_valid, 1);
      check("stall_m", res_m, hold_m);
      check("stall_id", res_id, hold_id);
    end
    req_valid = v;
    res_ready = rr;
    drive_ops();
    #1;
    check("req_ready", req_ready, exp_ready);
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ready[i]) begin
        e.id = 2'(i);
        e.m  = 40'(longint'(a_op[i]) * longint'(b_op[i]));
        sb.push_back(e);
      end
    end
    if (res_valid && rr) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_result: id %0d m %0h with empty scoreboard", res_id, res_m);
      end else begin
        e = sb.pop_front();
        check("res_m", res_m, e.m);
        check("res_id", res_id, e.id);
      end
    end
    stalled = res_valid && !rr;
    hold_m  = res_m;
    hold_id = res_id;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pointer walk: starts at 3 after the extremes test.
    vecs.push_back('{4'b1001, 1'b1, 4'b1000});
    vecs.push_back('{4'b1001, 1'b1, 4'b0001});
    vecs.push_back('{4'b0100, 1'b1, 4'b0100});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000});
    vecs.push_back('{4'b1000, 1'b1, 4'b1000});
    for (int r = 0; r < 2; r++) begin
      vecs.push_back('{4'b1111, 1'b1, 4'b0001});
      vecs.push_back('{4'b1111, 1'b1, 4'b0010});
      vecs.push_back('{4'b1111, 1'b1, 4'b0100});
      vecs.push_back('{4'b1111, 1'b1, 4'b1000});
    end
    vecs.push_back('{4'b0000, 1'b1, 4'b0000});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000});
    // Backpressure: two in flight, three stalled cycles with requests toggling, then drain.
    vecs.push_back('{4'b0011, 1'b0, 4'b0001});
    vecs.push_back('{4'b0011, 1'b0, 4'b0010});
    vecs.push_back('{4'b1111, 1'b0, 4'b0000});
    vecs.push_back('{4'b0111, 1'b0, 4'b0000});
    vecs.push_back('{4'b1110, 1'b0, 4'b0000});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000});
    vecs.push_back('{4'b1111, 1'b1, 4'b0100});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000});
    vecs.push_back('{4'b0000, 1'b1, 4'b0000});

    rst_n     = 1'b0;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    rand_ops();
    drive_ops();
    #2;
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res_m", res_m, 0);
    check("rst_req_ready", req_ready, 0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request, PIPE=2 latency.
    rand_ops();
    a_op[0] = 20'sd3;
    b_op[0] = -20'sd4;
    cycle(4'b0001, 1'b1, 4'b0001);
    check("t1_early_valid", res_valid, 0);
    check("t1_busy", busy, 1);
    cycle(4'b0000, 1'b1, 4'b0000);
    check("t1_valid", res_valid, 1);
    check("t1_m", res_m, -64'sd12);
    check("t1_id", res_id, 0);

    // Operand extremes.
    rand_ops();
    a_op[1] = -20'sd524288;
    b_op[1] = -20'sd524288;
    cycle(4'b0010, 1'b1, 4'b0010);
    rand_ops();
    a_op[2] = -20'sd524288;
    b_op[2] = 20'sd524287;
    cycle(4'b0100, 1'b1, 4'b0100);
    check("t2_m_pos", res_m, 64'sd274877906944);

    foreach (vecs[i]) begin
      rand_ops();
      cycle(vecs[i].valid, vecs[i].rr, vecs[i].exp_ready);
    end

    // Reset with two entries in flight.
    rand_ops();
    cycle(4'b0011, 1'b1, 4'b0001);
    cycle(4'b0011, 1'b1, 4'b0010);
    check("t6_busy_before", busy, 1);
    req_valid = 4'b1111;
    rst_n     = 1'b0;
    #1;
    check("t6_res_valid", res_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_res_m", res_m, 0);
    check("t6_req_ready", req_ready, 0);
    sb.delete();
    stalled = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, 4'b0000);
    check("t6_busy_after", busy, 0);
    rand_ops();
    cycle(4'b1111, 1'b1, 4'b0001);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, 4'b0000);

    check("sb_empty", sb.size(), 0);
    check("busy_end", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
